// File: rtl/tcdm_lrwait_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tcdm_lrwait_scheduler
// Purpose  : Per-bank LRWait reservation controller. Serialises LR/SC on one
//            reserved word, parks competing LRWait requests in a FIFO wait
//            queue, replays them on release, and merges bank responses with
//            locally generated SC-failure responses into one stream.
// Revision : 1.0 - initial release
// ============================================================================

package tcdm_lrwait_pkg;
  typedef struct packed {
    logic [7:0] core_id;
    logic       lrwait;
  } bank_metadata_t;

  typedef struct packed {
    logic [31:0]    addr;
    bank_metadata_t meta;
    logic [3:0]     amo;
    logic           write;
    logic [31:0]    wdata;
    logic [3:0]     be;
  } tcdm_req_t;

  typedef struct packed {
    bank_metadata_t meta;
    logic [31:0]    rdata;
  } tcdm_resp_t;
endpackage

module tcdm_lrwait_scheduler
  import tcdm_lrwait_pkg::*;
#(
  parameter int unsigned LrWaitQueueSize = 256,
  parameter int unsigned RespFifoDepth   = 2,
  parameter logic [3:0]  AmoLr           = 4'hA,
  parameter logic [3:0]  AmoSc           = 4'hB
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  tcdm_req_t  req_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  output tcdm_resp_t resp_o,
  output logic       resp_valid_o,
  input  logic       resp_ready_i,
  output tcdm_req_t  bank_req_o,
  output logic       bank_req_valid_o,
  input  logic       bank_req_ready_i,
  input  tcdm_resp_t bank_resp_i,
  input  logic       bank_resp_valid_i
);
  localparam int unsigned QPtrW = (LrWaitQueueSize > 1) ? $clog2(LrWaitQueueSize) : 1;
  localparam int unsigned QCntW = $clog2(LrWaitQueueSize + 1);
  localparam int unsigned FPtrW = (RespFifoDepth > 1) ? $clog2(RespFifoDepth) : 1;
  localparam int unsigned FCntW = $clog2(RespFifoDepth + 1);

  localparam logic [QCntW-1:0] QFull  = QCntW'(LrWaitQueueSize);
  localparam logic [QPtrW-1:0] QLast  = QPtrW'(LrWaitQueueSize - 1);
  localparam logic [FPtrW-1:0] FLast  = FPtrW'(RespFifoDepth - 1);
  localparam logic [FCntW:0]   FDepth = (FCntW + 1)'(RespFifoDepth);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StReserved = 2'd1;
  localparam logic [1:0] StReplay   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      res_addr_q, res_addr_d;
  bank_metadata_t   head_meta_q, head_meta_d;
  logic             res_valid_q, res_valid_d;
  logic [QPtrW-1:0] q_wptr_q, q_wptr_d, q_rptr_q, q_rptr_d;
  logic [QCntW-1:0] q_count_q, q_count_d;
  logic             inflight_q, inflight_d;
  logic             infl_sc_ok_q, infl_sc_ok_d;
  logic             infl_clr_lw_q, infl_clr_lw_d;
  logic [FPtrW-1:0] f_wptr_q, f_wptr_d, f_rptr_q, f_rptr_d;
  logic [FCntW-1:0] f_count_q, f_count_d;

  bank_metadata_t   queue_q [LrWaitQueueSize];
  tcdm_resp_t       fifo_q  [RespFifoDepth];

  logic       is_lr, is_sc, is_head, addr_hit, q_full, credit_ok, local_ok;
  logic       do_fwd, do_local, do_enq, start_res, sc_ok, clr_lw, rel, brk;
  tcdm_req_t  fwd_req;
  logic       req_hs, bank_hs, f_push, f_pop;
  tcdm_resp_t f_push_data;

  // Classify the incoming request against the current reservation.
  always_comb begin
    is_lr     = (req_i.amo == AmoLr);
    is_sc     = (req_i.amo == AmoSc);
    is_head   = (req_i.meta.core_id == head_meta_q.core_id);
    addr_hit  = (req_i.addr == res_addr_q);
    q_full    = (q_count_q == QFull);
    // A bank access must have a guaranteed FIFO slot for its response.
    credit_ok = (({1'b0, f_count_q} + {{FCntW{1'b0}}, inflight_q}) < FDepth);
    // Local responses may not collide with a landing bank response.
    local_ok  = !inflight_q && ({1'b0, f_count_q} < FDepth);
    do_fwd    = 1'b1;
    do_local  = 1'b0;
    do_enq    = 1'b0;
    start_res = 1'b0;
    sc_ok     = 1'b0;
    clr_lw    = 1'b0;
    rel       = 1'b0;
    brk       = 1'b0;
    fwd_req   = req_i;
    case (state_q)
      StIdle: begin
        if (is_lr && req_i.meta.lrwait) begin
          fwd_req.amo   = 4'h0;
          fwd_req.write = 1'b0;
          start_res     = 1'b1;
        end
      end
      StReserved: begin
        if (is_lr) begin
          fwd_req.amo   = 4'h0;
          fwd_req.write = 1'b0;
          if (req_i.meta.lrwait && addr_hit && !is_head) begin
            if (!q_full) begin
              do_fwd = 1'b0;
              do_enq = 1'b1;
            end else begin
              clr_lw = 1'b1;
            end
          end
        end else if (is_sc) begin
          if (is_head && res_valid_q && addr_hit) begin
            fwd_req.amo   = 4'h0;
            fwd_req.write = 1'b1;
            sc_ok         = 1'b1;
            rel           = 1'b1;
          end else begin
            do_fwd   = 1'b0;
            do_local = 1'b1;
            rel      = is_head;
          end
        end else if (req_i.write && addr_hit) begin
          brk = 1'b1;
        end
      end
      default: do_fwd = 1'b0;
    endcase
  end

  // Handshakes toward the interconnect and the bank, including replay reads.
  always_comb begin
    req_ready_o      = 1'b0;
    bank_req_valid_o = 1'b0;
    bank_req_o       = fwd_req;
    if (!rst_i) begin
      if (state_q == StReplay) begin
        bank_req_o       = '0;
        bank_req_o.addr  = res_addr_q;
        bank_req_o.meta  = queue_q[q_rptr_q];
        bank_req_o.be    = 4'hF;
        bank_req_valid_o = credit_ok;
      end else begin
        bank_req_valid_o = req_valid_i && do_fwd && credit_ok;
        if (do_fwd)        req_ready_o = bank_req_ready_i && credit_ok;
        else if (do_local) req_ready_o = local_ok;
        else               req_ready_o = 1'b1;
      end
    end
    req_hs  = req_valid_i && req_ready_o;
    bank_hs = bank_req_valid_o && bank_req_ready_i;
  end

  // Reservation, wait queue and in-flight bookkeeping.
  always_comb begin
    state_d       = state_q;
    res_addr_d    = res_addr_q;
    head_meta_d   = head_meta_q;
    res_valid_d   = res_valid_q;
    q_wptr_d      = q_wptr_q;
    q_rptr_d      = q_rptr_q;
    q_count_d     = q_count_q;
    inflight_d    = bank_hs;
    infl_sc_ok_d  = bank_hs && sc_ok;
    infl_clr_lw_d = bank_hs && clr_lw;
    if (state_q == StReplay) begin
      if (bank_hs) begin
        head_meta_d = queue_q[q_rptr_q];
        res_valid_d = 1'b1;
        q_rptr_d    = (q_rptr_q == QLast) ? '0 : q_rptr_q + QPtrW'(1);
        q_count_d   = q_count_q - QCntW'(1);
        state_d     = StReserved;
      end
    end else if (req_hs) begin
      if (start_res) begin
        res_addr_d  = req_i.addr;
        head_meta_d = req_i.meta;
        res_valid_d = 1'b1;
        state_d     = StReserved;
      end
      if (do_enq) begin
        q_wptr_d  = (q_wptr_q == QLast) ? '0 : q_wptr_q + QPtrW'(1);
        q_count_d = q_count_q + QCntW'(1);
      end
      if (brk) res_valid_d = 1'b0;
      if (rel) begin
        res_valid_d = 1'b0;
        state_d     = (q_count_q == '0) ? StIdle : StReplay;
      end
    end
  end

  // Response FIFO: bank responses (patched for SC success / full-queue LR) and local failures.
  always_comb begin
    resp_valid_o = !rst_i && (f_count_q != '0);
    resp_o       = fifo_q[f_rptr_q];
    f_pop        = resp_valid_o && resp_ready_i;
    f_push       = bank_resp_valid_i || (req_hs && do_local);
    f_push_data  = bank_resp_i;
    if (bank_resp_valid_i) begin
      if (infl_sc_ok_q)  f_push_data.rdata       = 32'd0;
      if (infl_clr_lw_q) f_push_data.meta.lrwait = 1'b0;
    end else begin
      f_push_data.meta  = req_i.meta;
      f_push_data.rdata = 32'd1;
    end
    f_wptr_d  = f_push ? ((f_wptr_q == FLast) ? '0 : f_wptr_q + FPtrW'(1)) : f_wptr_q;
    f_rptr_d  = f_pop  ? ((f_rptr_q == FLast) ? '0 : f_rptr_q + FPtrW'(1)) : f_rptr_q;
    f_count_d = f_count_q;
    case ({f_push, f_pop})
      2'b10:   f_count_d = f_count_q + FCntW'(1);
      2'b01:   f_count_d = f_count_q - FCntW'(1);
      default: f_count_d = f_count_q;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      res_addr_q    <= '0;
      head_meta_q   <= '0;
      res_valid_q   <= 1'b0;
      q_wptr_q      <= '0;
      q_rptr_q      <= '0;
      q_count_q     <= '0;
      inflight_q    <= 1'b0;
      infl_sc_ok_q  <= 1'b0;
      infl_clr_lw_q <= 1'b0;
      f_wptr_q      <= '0;
      f_rptr_q      <= '0;
      f_count_q     <= '0;
    end else begin
      state_q       <= state_d;
      res_addr_q    <= res_addr_d;
      head_meta_q   <= head_meta_d;
      res_valid_q   <= res_valid_d;
      q_wptr_q      <= q_wptr_d;
      q_rptr_q      <= q_rptr_d;
      q_count_q     <= q_count_d;
      inflight_q    <= inflight_d;
      infl_sc_ok_q  <= infl_sc_ok_d;
      infl_clr_lw_q <= infl_clr_lw_d;
      f_wptr_q      <= f_wptr_d;
      f_rptr_q      <= f_rptr_d;
      f_count_q     <= f_count_d;
    end
  end

  // Storage arrays; contents are only meaningful behind the pointers.
  always_ff @(posedge clk_i) begin
    if (req_hs && do_enq) queue_q[q_wptr_q] <= req_i.meta;
    if (f_push)           fifo_q[f_wptr_q]  <= f_push_data;
  end
endmodule
`default_nettype wire

// File: tb/tb_tcdm_lrwait_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcdm_lrwait_scheduler
// Purpose  : Directed plus randomized bench for tcdm_lrwait_scheduler with a
//            transaction-level reservation model and a one-cycle bank stub.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tcdm_lrwait_scheduler;
  import tcdm_lrwait_pkg::*;

  localparam logic [3:0] LR    = 4'hA;
  localparam logic [3:0] SC    = 4'hB;
  localparam int         QSIZE = 256;

  logic       clk = 1'b0;
  logic       rst_i;
  tcdm_req_t  req_i;
  logic       req_valid_i, req_ready_o;
  tcdm_resp_t resp_o;
  logic       resp_valid_o, resp_ready_i;
  tcdm_req_t  bank_req_o;
  logic       bank_req_valid_o, bank_req_ready_i;
  tcdm_resp_t bank_resp_i;
  logic       bank_resp_valid_i;

  always #5 clk = ~clk;

  tcdm_lrwait_scheduler #(
    .LrWaitQueueSize(QSIZE), .RespFifoDepth(2), .AmoLr(LR), .AmoSc(SC)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_i(req_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .resp_o(resp_o), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .bank_req_o(bank_req_o), .bank_req_valid_o(bank_req_valid_o),
    .bank_req_ready_i(bank_req_ready_i),
    .bank_resp_i(bank_resp_i), .bank_resp_valid_i(bank_resp_valid_i)
  );

  int n_tests = 0, n_fail = 0, n_acc = 0, n_resp = 0;
  bit rnd_mode = 1'b0;
  tcdm_resp_t last_resp;

  // Reference model: who holds the word, whether it is intact, who waits.
  bit             held;
  logic [31:0]    m_addr;
  logic [7:0]     m_head;
  bit             m_valid;
  bank_metadata_t wq[$];
  tcdm_req_t      exp_bank[$];
  tcdm_resp_t     exp_resp[$];
  logic [31:0]    exp_mem  [logic [31:0]];
  logic [31:0]    bank_mem [logic [31:0]];

  function automatic logic [31:0] mem_init(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic tcdm_req_t mk(int core, bit lw, logic [3:0] amo, bit wr,
                                   logic [31:0] addr, logic [31:0] wd);
    tcdm_req_t r;
    r.addr = addr; r.meta.core_id = 8'(core); r.meta.lrwait = lw;
    r.amo = amo; r.write = wr; r.wdata = wd; r.be = 4'hF;
    return r;
  endfunction

  function automatic tcdm_req_t plain(tcdm_req_t r, bit wr);
    tcdm_req_t p = r;
    p.amo = 4'h0; p.write = wr;
    return p;
  endfunction

  // Bank ops return the old word; writes update memory.
  function automatic void expect_bank(tcdm_req_t r, bank_metadata_t rm, bit sc_ok);
    tcdm_resp_t e;
    logic [31:0] old = exp_mem.exists(r.addr) ? exp_mem[r.addr] : mem_init(r.addr);
    if (r.write) exp_mem[r.addr] = r.wdata;
    exp_bank.push_back(r);
    e.meta = rm; e.rdata = sc_ok ? 32'd0 : old;
    exp_resp.push_back(e);
  endfunction

  function automatic void release_res();
    bank_metadata_t w;
    tcdm_req_t rr;
    if (wq.size() == 0) begin
      held = 1'b0;
    end else begin
      w = wq.pop_front();
      m_head = w.core_id; m_valid = 1'b1;
      rr = '0; rr.addr = m_addr; rr.meta = w; rr.be = 4'hF;
      expect_bank(rr, w, 1'b0);
    end
  endfunction

  function automatic void model_accept(tcdm_req_t r);
    bank_metadata_t rm = r.meta;
    tcdm_resp_t f;
    if (!held) begin
      if (r.amo == LR && r.meta.lrwait) begin
        held = 1'b1; m_addr = r.addr; m_head = r.meta.core_id; m_valid = 1'b1;
        expect_bank(plain(r, 1'b0), rm, 1'b0);
      end else begin
        expect_bank(r, rm, 1'b0);
      end
    end else if (r.amo == LR) begin
      if (r.meta.lrwait && r.addr == m_addr && r.meta.core_id != m_head) begin
        if (wq.size() < QSIZE) begin
          wq.push_back(r.meta);
          return;
        end
        rm.lrwait = 1'b0;
      end
      expect_bank(plain(r, 1'b0), rm, 1'b0);
    end else if (r.amo == SC) begin
      if (r.meta.core_id == m_head && m_valid && r.addr == m_addr) begin
        expect_bank(plain(r, 1'b1), rm, 1'b1);
        release_res();
      end else begin
        f.meta = r.meta; f.rdata = 32'd1;
        exp_resp.push_back(f);
        if (r.meta.core_id == m_head) release_res();
      end
    end else begin
      if (r.write && r.addr == m_addr) m_valid = 1'b0;
      expect_bank(r, rm, 1'b0);
    end
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, then drive the bank stub after the rising edge.
  task automatic tick();
    tcdm_req_t  b, e;
    tcdm_resp_t er, nxt;
    bit bhs;
    logic [31:0] old;
    nxt = '0;
    @(negedge clk);
    if (!rst_i && req_valid_i && req_ready_o) begin
      n_acc++;
      model_accept(req_i);
    end
    bhs = bank_req_valid_o && bank_req_ready_i;
    if (bhs) begin
      b = bank_req_o;
      chk("bank_req_expected", 128'(exp_bank.size() > 0), 128'(1));
      if (exp_bank.size() > 0) begin
        e = exp_bank.pop_front();
        chk("bank_req", 128'(b), 128'(e));
      end
      old = bank_mem.exists(b.addr) ? bank_mem[b.addr] : mem_init(b.addr);
      if (b.write) bank_mem[b.addr] = b.wdata;
      nxt.meta = b.meta; nxt.rdata = old;
    end
    if (resp_valid_o && resp_ready_i) begin
      chk("resp_expected", 128'(exp_resp.size() > 0), 128'(1));
      if (exp_resp.size() > 0) begin
        er = exp_resp.pop_front();
        chk("resp", 128'(resp_o), 128'(er));
      end
      last_resp = resp_o;
      n_resp++;
    end
    @(posedge clk); #1;
    bank_resp_valid_i = bhs;
    bank_resp_i       = nxt;
    if (rnd_mode) begin
      bank_req_ready_i = ($urandom_range(0, 3) != 0);
      resp_ready_i     = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send(tcdm_req_t r);
    int acc0 = n_acc;
    int k = 0;
    req_i = r; req_valid_i = 1'b1;
    while (n_acc == acc0 && k < 200) begin tick(); k++; end
    chk("req_accepted", 128'(n_acc != acc0), 128'(1));
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_resp.size() != 0 || exp_bank.size() != 0) && k < 500) begin tick(); k++; end
    repeat (4) tick();
    chk("drain_resp_left", 128'(exp_resp.size()), 128'(0));
  endtask

  initial begin
    int r0;
    rst_i = 1'b1; req_valid_i = 1'b1; req_i = mk(1, 1, LR, 0, 32'h100, 0);
    bank_req_ready_i = 1'b1; resp_ready_i = 1'b1;
    bank_resp_valid_i = 1'b0; bank_resp_i = '0;
    held = 1'b0; m_valid = 1'b0; m_addr = '0; m_head = '0; last_resp = '0;
    bank_mem[32'h100] = 32'h55; exp_mem[32'h100] = 32'h55;

    // Reset held with a pending request: nothing may handshake.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req_ready", 128'(req_ready_o), 128'(0));
      chk("rst_bank_valid", 128'(bank_req_valid_o), 128'(0));
      chk("rst_resp_valid", 128'(resp_valid_o), 128'(0));
      @(posedge clk); #1;
    end
    rst_i = 1'b0; req_valid_i = 1'b0;
    tick();

    // Basic reservation.
    send(mk(3, 1, LR, 0, 32'h100, 0)); drain();
    chk("basic_lr_rdata", 128'(last_resp.rdata), 128'(32'h55));
    send(mk(3, 0, SC, 1, 32'h100, 32'h77)); drain();
    chk("basic_sc_rdata", 128'(last_resp.rdata), 128'(0));
    chk("basic_sc_mem", 128'(bank_mem[32'h100]), 128'(32'h77));
    // Back in IDLE: another core gets a fresh reservation immediately.
    send(mk(6, 1, LR, 0, 32'h100, 0)); drain();
    chk("idle_again_core", 128'(last_resp.meta.core_id), 128'(6));
    send(mk(6, 0, SC, 1, 32'h100, 32'h78)); drain();

    // Queued waiters.
    r0 = n_resp;
    send(mk(3, 1, LR, 0, 32'h100, 0));
    send(mk(5, 1, LR, 0, 32'h100, 0));
    send(mk(7, 1, LR, 0, 32'h100, 0));
    drain();
    chk("queued_no_resp", 128'(n_resp - r0), 128'(1));
    send(mk(3, 0, SC, 1, 32'h100, 32'h11)); drain();
    chk("replay_core5", 128'(last_resp.meta.core_id), 128'(5));
    send(mk(5, 0, SC, 1, 32'h100, 32'h12)); drain();
    chk("replay_core7", 128'(last_resp.meta.core_id), 128'(7));
    send(mk(7, 0, SC, 1, 32'h100, 32'h13)); drain();

    // Broken reservation.
    send(mk(3, 1, LR, 0, 32'h100, 0));
    send(mk(5, 1, LR, 0, 32'h100, 0));
    send(mk(9, 0, 4'h0, 1, 32'h100, 32'h99));
    send(mk(3, 0, SC, 1, 32'h100, 32'h44)); drain();
    chk("broken_no_write", 128'(bank_mem[32'h100]), 128'(32'h99));
    send(mk(5, 0, SC, 1, 32'h100, 32'h66)); drain();
    chk("replayed_sc_ok", 128'(last_resp.rdata), 128'(0));

    // Non-head SC.
    send(mk(3, 1, LR, 0, 32'h100, 0));
    send(mk(4, 0, SC, 1, 32'h100, 32'h21)); drain();
    chk("nonhead_sc_fail", 128'(last_resp.rdata), 128'(1));
    send(mk(3, 0, SC, 1, 32'h100, 32'h22)); drain();
    chk("head_sc_after_nonhead", 128'(last_resp.rdata), 128'(0));

    // Full wait queue, then a reset mid-operation.
    send(mk(0, 1, LR, 0, 32'h200, 0));
    for (int i = 0; i < QSIZE; i++) send(mk((i % 255) + 1, 1, LR, 0, 32'h200, 0));
    send(mk(8'h80, 1, LR, 0, 32'h200, 0)); drain();
    chk("full_queue_lrwait", 128'(last_resp.meta.lrwait), 128'(0));
    chk("full_queue_core", 128'(last_resp.meta.core_id), 128'(8'h80));
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
    held = 1'b0; m_valid = 1'b0; wq.delete();
    repeat (6) tick();

    // Response backpressure.
    r0 = n_acc;
    resp_ready_i = 1'b0;
    req_i = mk(2, 0, 4'h0, 0, 32'h300, 0); req_valid_i = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk("bp_accepted", 128'(n_acc - r0), 128'(2));
    chk("bp_req_ready_low", 128'(req_ready_o), 128'(0));
    chk("bp_resp_valid", 128'(resp_valid_o), 128'(1));
    @(posedge clk); #1;
    req_valid_i = 1'b0; resp_ready_i = 1'b1;
    r0 = n_resp;
    drain();
    chk("bp_no_loss", 128'(n_resp - r0), 128'(2));

    // Randomized traffic on two contended words.
    rnd_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int core = $urandom_range(0, 5);
      int kind = $urandom_range(0, 4);
      logic [31:0] a = ($urandom_range(0, 1) != 0) ? 32'h104 : 32'h100;
      logic [31:0] wd = $urandom;
      case (kind)
        0:       send(mk(core, 1, LR, 0, a, wd));
        1:       send(mk(core, $urandom_range(0, 1) != 0, LR, 0, a, wd));
        2:       send(mk(core, 0, SC, 1, a, wd));
        3:       send(mk(core, 0, 4'h0, 1, a, wd));
        default: send(mk(core, 0, 4'h0, 0, a, wd));
      endcase
      if ($urandom_range(0, 3) == 0) tick();
    end
    rnd_mode = 1'b0; bank_req_ready_i = 1'b1; resp_ready_i = 1'b1;
    drain();
    chk("end_bank_left", 128'(exp_bank.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/tcdm_lrwait_scheduler.md
# tcdm_lrwait_scheduler

Per-bank LRWait reservation controller placed between the TCDM interconnect and one TCDM bank of a MemPool tile. It serialises LR/SC sequences on a single reserved word. Additional LRWait requests to the reserved address are parked in a FIFO wait queue instead of failing, and each waiter's LR is replayed to the bank when the current holder finishes. It also merges bank responses with locally generated SC-failure responses into one response stream.

## Interface
- `LrWaitQueueSize`, 256: depth of the wait queue, in entries of `bank_metadata_t`.
- `RespFifoDepth`, 2: depth of the output response FIFO.
- `AmoLr`, 4'hA: LR encoding of the `amo` field.
- `AmoSc`, 4'hB: SC encoding of the `amo` field.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  `tcdm_req_t`  request from the interconnect (addr, meta incl. lrwait, amo, write, wdata, be).
- `req_valid_i` / `req_ready_o`  in/out  1  request handshake.
- `resp_o`  out  `tcdm_resp_t`  response (meta, rdata).
- `resp_valid_o` / `resp_ready_i`  out/in  1  response handshake.
- `bank_req_o`  out  `tcdm_req_t`  request to the bank.
- `bank_req_valid_o` / `bank_req_ready_i`  out/in  1  bank request handshake.
- `bank_resp_i`  in  `tcdm_resp_t`  bank response.
- `bank_resp_valid_i`  in  1  bank response valid. No backpressure is possible.

## Operation
State: FSM `IDLE` / `RESERVED` / `REPLAY`; `res_addr`; `head_meta`; `res_valid` (reservation not broken); circular wait queue with `wptr`, `rptr` and `count`.

Handling by state and request type:
- **IDLE**
  - LR with `meta.lrwait=1`: forward as a plain read (amo=0, write=0). Latch `res_addr` and `head_meta`, set `res_valid=1`, go to `RESERVED`.
  - Any other request: forwarded unchanged.
- **RESERVED, LRWait LR to `res_addr` from a non-head core**
  - If `count<LrWaitQueueSize`: push its meta to the queue. Nothing is sent to the bank and no response is produced now.
  - If the queue is full: forward as a plain read and return the response with `meta.lrwait=0`. The requester holds no reservation.
- **RESERVED, LR to another address, or LR with `lrwait=0`:** forward as a plain read with no reservation change.
- **RESERVED, LR from the head core:** forward as a plain read; the reservation is kept.
- **RESERVED, SC from the head with `res_valid=1` and address equal to `res_addr`:** forward as a plain write (amo=0, write=1). Replace the bank response `rdata` with 0 (success). The reservation is released.
- **RESERVED, SC failure cases:**
  - Cases: head SC with `res_valid=0`, head SC to another address, or SC from any non-head core.
  - Nothing is sent to the bank. A local response is pushed with `rdata=1` (fail) and the request's meta.
  - A failing head SC also releases the reservation. A failing non-head SC changes no state.
- **RESERVED, write to `res_addr` from any core:** forward and clear `res_valid`.
- **On release:** if `count==0`, go to `IDLE`. Otherwise go to `REPLAY`.
- **REPLAY**
  - `req_ready_o=0`.
  - Issue a plain read to `res_addr` carrying the meta at `rptr`.
  - On the bank handshake: pop the entry, make it `head_meta`, set `res_valid=1`, go to `RESERVED`.
- **Reset mid-operation:** queue flushed, reservation dropped, queued cores never receive a response. Acceptable because the whole tile is reset.

## Timing
- Reset values: `req_ready_o=0`, `bank_req_valid_o=0`, `resp_valid_o=0`, FSM `IDLE`, `count=0`, `wptr=rptr=0`, `res_valid=0`, response FIFO empty.
- The bank responds exactly 1 cycle after a bank handshake. `inflight` counts 0 or 1.
- **Credit rule:** a bank request is issued only if `fifo_count + inflight < RespFifoDepth`.
- **Local failure responses:**
  - A request needing one is accepted only if `inflight==0` (no bank response lands this cycle) and `fifo_count < RespFifoDepth`.
  - Otherwise `req_ready_o=0`.
- **Combinational forward path:** `req_ready_o` equals `bank_req_ready_i` gated by state and credit. Latency is request handshake to bank in the same cycle, then response after 1 cycle of bank latency plus 1 cycle of FIFO.
- **Queue-only requests:** an LR that is only queued is accepted in 1 cycle with no bank access.
- **Queue pointers:** wrap modulo `LrWaitQueueSize`. Push and pop never occur in the same cycle, because REPLAY blocks input.
- The response FIFO is first-in, first-out in arrival order; responses are never reordered relative to their entry.

## Test plan
- **Reset:** hold `rst_i=1` for 3 cycles with `req_valid_i=1` -> no handshakes; all valids 0.
- **Basic reservation:** core 3 LRWait to 0x100 (bank rdata 0x55), then core 3 SC 0x100 wdata 0x77 -> LR response rdata 0x55; bank sees write 0x77; SC response rdata 0; FSM returns to `IDLE`.
- **Queued waiters:** core 3 LRWait to 0x100, then cores 5 and 7 LRWait to 0x100 -> 5 and 7 get no response; core 3 SC -> replay read for core 5, core 5 gets its LR response. Core 5 SC -> replay for core 7.
- **Broken reservation:** core 3 LRWait to 0x100, core 9 store to 0x100, core 3 SC -> core 3 SC response rdata 1 with no bank write; queued waiter replayed.
- **Non-head SC:** core 4 SC to 0x100 while core 3 holds the reservation -> local rdata 1; reservation unchanged.
- **Full queue:** fill the queue with 256 waiters, send a 257th LRWait -> forwarded as a plain read, response `meta.lrwait=0`.
- **Backpressure:** `resp_ready_i=0` -> at most 2 responses buffered; `req_ready_o` falls; no response lost.
